trng_postproc: RTL and testbench
================================

// Module: trng_postproc
// PURPOSE
//  Consumes the raw ring-oscillator entropy bit and turns it into bytes for the top-level outputs.
//  - Synchronizes the raw bit into clk and samples it every SAMPLE_DIV cycles.
//  - Runs a repetition-count health test, optionally debiases (von Neumann), and packs bits MSB-first.
//  - Offers each byte on a one-entry valid/ready output register.
// PARAMETERS
//  SAMPLE_DIV  4   clk cycles per raw sample (>=1)
//  RCT_CUTOFF  32  identical consecutive raw samples that trip health_fail (>=2)
// PORTS
//  clk        in   1  single clock
//  rst_n      in   1  synchronous, active-HIGH reset (1 = reset, despite the name)
//  raw_bit    in   1  asynchronous raw entropy bit from the ring oscillator
//  enable     in   1  1 = sample and process
//  clear_fail in   1  1-cycle pulse; clears health_fail and overrun
//  out_ready  in   1  consumer accepts out_data this cycle
//  out_data   out  8  packed random byte, stable while out_valid && !out_ready
//  out_valid  out  1  out_data holds an unconsumed byte
//  health_fail out 1  sticky repetition-count failure
//  overrun    out  1  sticky; a completed byte was dropped
// BEHAVIOUR
//  - Reset: all outputs 0; divider, run counter, bit_cnt, shift register and pair state cleared.
//  - Sync: raw_bit passes through 2 flops, giving raw_s with 2-cycle latency.
//  - Divider: counts 0..SAMPLE_DIV-1 while enable=1; strobe when count==SAMPLE_DIV-1, then wraps to 0.
//    With SAMPLE_DIV=1, strobe fires every cycle.
//  - enable=0:
//    - divider held at 0, pair state reset to FIRST, partial byte (bit_cnt) discarded;
//    - output register, run counter and sticky flags retained.
//  - RCT, evaluated on every strobe on raw_s before debiasing:
//    - raw_s==last: run++ (saturating at RCT_CUTOFF); otherwise run=1; last updates every strobe.
//    - When run reaches RCT_CUTOFF, health_fail<=1 on that strobe.
//  - While health_fail=1:
//    - no bits enter the packer, and bit_cnt/pair state are cleared;
//    - a byte already in the output register is still delivered.
//  - clear_fail: health_fail<=0, overrun<=0, run<=0; the next strobe sets run=1.
//    A fail that trips in the same cycle as clear_fail wins (flag stays 1).
//  - Packer: an accepted bit b does shreg<={shreg[6:0],b} and bit_cnt++.
//    - On the 8th bit, the byte is complete in the same cycle.
//  - Output load when a byte completes:
//    - if !out_valid, or out_valid && out_ready: out_data<=byte, out_valid<=1;
//    - a simultaneous consume and load leaves out_valid=1 with the new byte;
//    - otherwise the byte is dropped and overrun<=1;
//    - in both cases bit_cnt returns to 0.
//  - Handshake: out_valid && out_ready with no load gives out_valid<=0 next cycle.
//    out_data holds its last value after consumption.
//  - Latency: raw edge to first use in a strobe takes at most 2+SAMPLE_DIV cycles.
//    A completing bit shows on out_valid 1 cycle after its strobe.
// CONFIGURATION
//  TRNG_VN_DEBIAS_EN defined: von Neumann corrector between RCT and packer, states FIRST/SECOND.
//    - FIRST, on strobe: b0<=raw_s, go to SECOND.
//    - SECOND, on strobe: if raw_s!=b0, accept b0; else discard the pair; go to FIRST.
//    - About 4 raw samples per output bit on average.
//  TRNG_VN_DEBIAS_EN undefined: every strobe's raw_s goes straight to the packer.
//    No pair state is implemented.
// TESTING  (SAMPLE_DIV=1, RCT_CUTOFF=32, out_ready=1 unless noted)
//  1. VN on: 8 pairs "1,0" then 8 pairs "0,1" -> bytes 8'hFF then 8'h00, overrun=0.
//  2. VN on: 20 pairs alternating "0,0"/"1,1" -> no out_valid; health_fail stays 0.
//  3. VN off: raw 1,0,1,0,1,0,1,0 -> out_data=8'hAA, out_valid 1 cycle after 8th strobe.
//  4. raw held 1 for 32 strobes -> health_fail=1 on 32nd strobe, no bytes afterwards.
//     Then clear_fail pulse and alternating raw -> bytes resume.
//  5. VN off, out_ready=0, 16 strobes of 1,0,... -> out_data=8'hAA held, overrun=1.
//     Then out_ready=1 -> out_valid falls next cycle.
//  6. rst_n=1 after 5 bits of a byte -> all outputs 0.
//     The next 8 samples 0xC3 pattern -> out_data=8'hC3.

Source files
------------

// File: rtl/trng_postproc.sv
// Entropy post-processor: sync + sample divider, repetition-count health test, packing into output bytes.
// Define TRNG_VN_DEBIAS_EN to insert a von Neumann corrector between the health test and the packer.
module trng_postproc #(
    parameter int SAMPLE_DIV = 4,
    parameter int RCT_CUTOFF = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_bit,
    input  logic       enable,
    input  logic       clear_fail,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       health_fail,
    output logic       overrun
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int RUN_W = $clog2(RCT_CUTOFF + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RCT_CUTOFF);

    logic             sync1_q, raw_s_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             last_q, last_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             fail_q, fail_d;
    logic             ovr_q, ovr_d;
    logic [6:0]       shreg_q, shreg_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;

    logic             strobe;
    logic             trip;
    logic             bit_vld;
    logic             bit_val;
    logic             byte_done;
    logic [7:0]       byte_val;
    logic             ovr_set;

    assign strobe = enable && (div_q == DIV_LAST);

    always_comb begin
        div_d = '0;
        if (enable && !strobe) begin
            div_d = div_q + 1'b1;
        end
    end

    // Repetition-count test runs on every strobe, ahead of any debiasing.
    always_comb begin
        last_d = last_q;
        run_d  = run_q;
        trip   = 1'b0;
        if (strobe) begin
            last_d = raw_s_q;
            if (raw_s_q == last_q) begin
                run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
            end else begin
                run_d = RUN_W'(1);
            end
            trip = (run_d == RUN_MAX);
        end
        if (clear_fail) begin
            run_d = '0;
        end
        fail_d = trip | (fail_q & ~clear_fail);
    end

`ifdef TRNG_VN_DEBIAS_EN
    typedef enum logic {FIRST, SECOND} vn_state_t;
    vn_state_t state_q, state_d;
    logic      b0_q, b0_d;

    always_comb begin
        state_d = state_q;
        b0_d    = b0_q;
        bit_vld = 1'b0;
        bit_val = b0_q;
        if (!enable || fail_q) begin
            state_d = FIRST;
        end else if (strobe) begin
            case (state_q)
                FIRST: begin
                    b0_d    = raw_s_q;
                    state_d = SECOND;
                end
                SECOND: begin
                    bit_vld = (raw_s_q != b0_q);
                    state_d = FIRST;
                end
                default: state_d = FIRST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= FIRST;
            b0_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            b0_q    <= b0_d;
        end
    end
`else
    assign bit_vld = strobe && !fail_q;
    assign bit_val = raw_s_q;
`endif

    // Packer: MSB-first, the byte is complete in the cycle its 8th bit arrives.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        byte_done = 1'b0;
        byte_val  = {shreg_q, bit_val};
        if (!enable || fail_q) begin
            bit_cnt_d = '0;
        end else if (bit_vld) begin
            shreg_d = byte_val[6:0];
            if (bit_cnt_q == 3'd7) begin
                byte_done = 1'b1;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_set = 1'b0;
        if (byte_done) begin
            if (!valid_q || out_ready) begin
                data_d  = byte_val;
                valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        ovr_d = ovr_set | (ovr_q & ~clear_fail);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync1_q   <= 1'b0;
            raw_s_q   <= 1'b0;
            div_q     <= '0;
            last_q    <= 1'b0;
            run_q     <= '0;
            fail_q    <= 1'b0;
            ovr_q     <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            sync1_q   <= raw_bit;
            raw_s_q   <= sync1_q;
            div_q     <= div_d;
            last_q    <= last_d;
            run_q     <= run_d;
            fail_q    <= fail_d;
            ovr_q     <= ovr_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign health_fail = fail_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_trng_postproc.sv
// Bench for trng_postproc: directed scenarios plus random traffic against a queue-based reference model.
module tb_trng_postproc;

    localparam int SD  = 1;
    localparam int CUT = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       raw_bit = 1'b0;
    logic       enable = 1'b0;
    logic       clear_fail = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       health_fail;
    logic       overrun;

    int n_chk = 0;
    int n_fail = 0;

    trng_postproc #(.SAMPLE_DIV(SD), .RCT_CUTOFF(CUT)) dut (
        .clk(clk), .rst_n(rst_n), .raw_bit(raw_bit), .enable(enable),
        .clear_fail(clear_fail), .out_ready(out_ready), .out_data(out_data),
        .out_valid(out_valid), .health_fail(health_fail), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit       m_raw_q[$];
    bit       m_bits[$];
    bit       m_pend[$];
    int       m_div, m_run;
    bit       m_last, m_hf, m_ov, m_valid;
    bit [7:0] m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit raw, input bit en, input bit clr, input bit rdy, input bit rst);
        bit raws, strobe, trip, acc, accb, done, drop;
        bit [7:0] nb;
        if (rst) begin
            m_raw_q = {1'b0, 1'b0};
            m_bits.delete();
            m_pend.delete();
            m_div = 0; m_run = 0; m_last = 0; m_hf = 0; m_ov = 0; m_valid = 0; m_data = 0;
            return;
        end
        raws = m_raw_q.pop_front();
        m_raw_q.push_back(raw);
        strobe = en && (m_div == SD - 1);
        m_div = (!en || strobe) ? 0 : m_div + 1;
        trip = 0; acc = 0; accb = 0; done = 0; drop = 0; nb = 0;
        if (strobe) begin
            if (raws == m_last) m_run = (m_run < CUT) ? m_run + 1 : CUT;
            else m_run = 1;
            m_last = raws;
            trip = (m_run == CUT);
        end
        if (clr) m_run = 0;
        if (!en || m_hf) begin
            m_bits.delete();
            m_pend.delete();
        end else if (strobe) begin
`ifdef TRNG_VN_DEBIAS_EN
            if (m_pend.size() == 0) begin
                m_pend.push_back(raws);
            end else begin
                if (raws != m_pend[0]) begin
                    acc = 1; accb = m_pend[0];
                end
                m_pend.delete();
            end
`else
            acc = 1; accb = raws;
`endif
            if (acc) begin
                m_bits.push_back(accb);
                if (m_bits.size() == 8) begin
                    for (int i = 0; i < 8; i++) nb = {nb[6:0], m_bits[i]};
                    m_bits.delete();
                    done = 1;
                end
            end
        end
        m_hf = trip ? 1'b1 : (clr ? 1'b0 : m_hf);
        if (done) begin
            if (!m_valid || rdy) begin
                m_data = nb; m_valid = 1;
            end else begin
                drop = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_ov = drop ? 1'b1 : (clr ? 1'b0 : m_ov);
    endtask

    task automatic cyc(input bit raw, input bit en, input bit clr, input bit rdy, input bit rst);
        raw_bit = raw; enable = en; clear_fail = clr; out_ready = rdy; rst_n = rst;
        @(posedge clk);
        model_step(raw, en, clr, rdy, rst);
        #1;
        check("valid", out_valid, m_valid);
        check("data", out_data, m_data);
        check("fail", health_fail, m_hf);
        check("ovr", overrun, m_ov);
    endtask

    function automatic bit getbit(input logic [31:0] pat, input int idx);
        return (idx >= 0) ? pat[idx] : 1'b0;
    endfunction

    // Two idle lead cycles prime the synchronizer so the n strobes see pat MSB-first.
    task automatic feed(input logic [31:0] pat, input int n, input bit rdy);
        cyc(getbit(pat, n - 1), 1'b0, 1'b0, rdy, 1'b0);
        cyc(getbit(pat, n - 2), 1'b0, 1'b0, rdy, 1'b0);
        for (int j = 0; j < n; j++) cyc(getbit(pat, n - 3 - j), 1'b1, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        bit seen;
        int hold;
        bit hold_val;
        m_raw_q = {1'b0, 1'b0};

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_fail", health_fail, 1'b0);
        check("rst_ovr", overrun, 1'b0);

`ifndef TRNG_VN_DEBIAS_EN
        feed(32'hAA, 8, 1'b0);
        check("aa_valid", out_valid, 1'b1);
        check("aa_data", out_data, 8'hAA);

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        feed(32'hAA, 8, 1'b0);
        feed(32'hAA, 8, 1'b0);
        check("ovr_set", overrun, 1'b1);
        check("ovr_data", out_data, 8'hAA);
        check("ovr_valid", out_valid, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("consume_valid", out_valid, 1'b0);
        check("consume_data", out_data, 8'hAA);
`else
        feed(32'hAAAA, 16, 1'b0);
        check("vn_ff_data", out_data, 8'hFF);
        check("vn_ff_valid", out_valid, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        feed(32'h5555, 16, 1'b0);
        check("vn_00_data", out_data, 8'h00);
        check("vn_00_valid", out_valid, 1'b1);
        check("vn_00_ovr", overrun, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        feed(32'h3333_3333, 32, 1'b1);
        feed(32'h33, 8, 1'b1);
        check("vn_eq_valid", out_valid, 1'b0);
        check("vn_eq_fail", health_fail, 1'b0);
`endif

        // Health test: 31 identical samples are fine, the 32nd trips.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        feed(32'hFFFF_FFFF, 31, 1'b1);
        check("rct_31", health_fail, 1'b0);
        feed(32'hFFFF_FFFF, 1, 1'b1);
        check("rct_32", health_fail, 1'b1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'(i % 2), 1'b1, 1'b0, 1'b1, 1'b0);
            if (i > 0 && out_valid) seen = 1;
        end
        check("rct_no_bytes", seen, 1'b0);
        check("rct_sticky", health_fail, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("clr_fail", health_fail, 1'b0);
        for (int i = 0; i < 24; i++) cyc(1'(i % 2), 1'b1, 1'b0, 1'b0, 1'b0);
        check("resume_valid", out_valid, 1'b1);

        // Reset in the middle of a byte.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        feed(32'h1F, 5, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, 8'h00);
        check("mid_rst_fail", health_fail, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        feed(32'hC3, 8, 1'b0);
        check("c3_data", out_data, 8'hC3);
        check("c3_valid", out_valid, 1'b1);

        // Random traffic, with occasional long constant runs to exercise the health test.
        hold = 0;
        hold_val = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            if (hold == 0 && $urandom_range(0, 199) == 0) begin
                hold = 40;
                hold_val = 1'($urandom_range(0, 1));
            end
            if (hold > 0) begin
                r = hold_val;
                hold--;
            end else begin
                r = 1'($urandom_range(0, 1));
            end
            cyc(r, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
